// File: rtl/mem_access_stage.sv
// MEM stage: byte-lane data RAM with programmable wait states, load extension,
// misalignment detection and branch/jump/jr PC redirect resolution.
module mem_access_stage #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic [1:0]  M_MemSize,
  input  logic        M_LoadUnsigned,
  input  logic [31:0] M_ALUResult,
  input  logic [31:0] M_WriteMemData,
  input  logic        M_Branch,
  input  logic        M_BNE,
  input  logic        M_ZeroFlag,
  input  logic [31:0] M_BranchAddResult,
  input  logic        M_jump,
  input  logic        M_jr,
  input  logic [25:0] M_offset,
  input  logic [31:0] M_PCinc,
  input  logic [31:0] M_Read1,
  output logic [31:0] MemReadData,
  output logic        MemStall,
  output logic        MisalignErr,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        Flush
);

  localparam int            CW       = $clog2(WAIT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_CYCLES);
  localparam bit            NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            stall;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              req, is_half, is_byte, misalign, aligned_req;
  logic              complete, do_store, do_load;
  logic [3:0]        lane_en;
  logic [31:0]       wdata_rep, rd_word, shifted, load_data;
  logic              taken, pc_src;
  logic [31:0]       target;
  logic              unused_bits;

  assign idx         = M_ALUResult[ADDR_W+1:2];
  assign off         = M_ALUResult[1:0];
  assign unused_bits = ^{M_ALUResult[31:ADDR_W+2], M_PCinc[27:0]};

  assign req         = M_MemRead | M_MemWrite;
  assign is_half     = (M_MemSize == 2'b01);
  assign is_byte     = (M_MemSize == 2'b10);
  assign misalign    = req & (is_half ? off[0] : (!is_byte && off != 2'b00));
  assign aligned_req = req & ~misalign;

  // Completion is gated by Reset so an abandoned or reset-time access never writes.
  assign complete = Reset & (NO_WAIT ? aligned_req : (state == BUSY && count == WAIT_CNT));
  assign do_store = complete & M_MemWrite;
  assign do_load  = complete & M_MemRead & ~M_MemWrite;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_req && !NO_WAIT) begin
          stall      = 1'b1;
          state_next = BUSY;
          count_next = CW'(1);
        end
      end
      BUSY: begin
        if (count == WAIT_CNT) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          stall      = 1'b1;
          count_next = count + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane_en   = 4'b1111;
    wdata_rep = M_WriteMemData;
    if (is_byte) begin
      lane_en   = 4'b0001 << off;
      wdata_rep = {4{M_WriteMemData[7:0]}};
    end else if (is_half) begin
      lane_en   = off[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{M_WriteMemData[15:0]}};
    end
  end

  // One narrow RAM per byte lane keeps partial stores a plain per-lane write enable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [2**ADDR_W];
      always_ff @(posedge Clk) begin
        if (do_store && lane_en[gi])
          lane_mem[idx] <= wdata_rep[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = lane_mem[idx];
    end
  endgenerate

  assign shifted = rd_word >> {off, 3'b000};

  always_comb begin
    load_data = '0;
    if (do_load) begin
      if (is_byte)
        load_data = M_LoadUnsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      else if (is_half)
        load_data = M_LoadUnsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      else
        load_data = rd_word;
    end
  end

  assign taken  = (M_Branch & M_ZeroFlag) | (M_BNE & ~M_ZeroFlag);
  assign pc_src = M_jr | M_jump | taken;

  always_comb begin
    target = '0;
    if (M_jr)
      target = M_Read1;
    else if (M_jump)
      target = {M_PCinc[31:28], M_offset, 2'b00};
    else if (taken)
      target = M_BranchAddResult;
  end

  assign MemReadData = load_data;
  assign MemStall    = stall & Reset;
  assign MisalignErr = misalign & Reset;
  assign PCSrc       = pc_src & Reset;
  assign PCTarget    = Reset ? target : 32'h0;
  assign Flush       = PCSrc;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
// share stimulus; loads are scored through an expected-data queue.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        M_MemRead, M_MemWrite, M_LoadUnsigned;
  logic [1:0]  M_MemSize;
  logic [31:0] M_ALUResult, M_WriteMemData, M_BranchAddResult, M_PCinc, M_Read1;
  logic        M_Branch, M_BNE, M_ZeroFlag, M_jump, M_jr;
  logic [25:0] M_offset;

  logic [31:0] rdata2, target2, rdata0, target0;
  logic        stall2, mis2, pcsrc2, flush2;
  logic        stall0, mis0, pcsrc0, flush0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;

  mem_access_stage #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
    .M_MemSize(M_MemSize), .M_LoadUnsigned(M_LoadUnsigned), .M_ALUResult(M_ALUResult),
    .M_WriteMemData(M_WriteMemData), .M_Branch(M_Branch), .M_BNE(M_BNE),
    .M_ZeroFlag(M_ZeroFlag), .M_BranchAddResult(M_BranchAddResult), .M_jump(M_jump),
    .M_jr(M_jr), .M_offset(M_offset), .M_PCinc(M_PCinc), .M_Read1(M_Read1),
    .MemReadData(rdata2), .MemStall(stall2), .MisalignErr(mis2), .PCSrc(pcsrc2),
    .PCTarget(target2), .Flush(flush2)
  );

  mem_access_stage #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
    .M_MemSize(M_MemSize), .M_LoadUnsigned(M_LoadUnsigned), .M_ALUResult(M_ALUResult),
    .M_WriteMemData(M_WriteMemData), .M_Branch(M_Branch), .M_BNE(M_BNE),
    .M_ZeroFlag(M_ZeroFlag), .M_BranchAddResult(M_BranchAddResult), .M_jump(M_jump),
    .M_jr(M_jr), .M_offset(M_offset), .M_PCinc(M_PCinc), .M_Read1(M_Read1),
    .MemReadData(rdata0), .MemStall(stall0), .MisalignErr(mis0), .PCSrc(pcsrc0),
    .PCTarget(target0), .Flush(flush0)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, exp_data;
    logic        exp_mis;
    int          exp_stall;
  } mvec_t;

  typedef struct {
    logic        br, bne, zero, jmp, jr;
    logic        exp_src;
    logic [31:0] exp_tgt;
  } bvec_t;

  mvec_t mvecs[$];
  bvec_t bvecs[$];

  function automatic mvec_t mk(logic rd, logic wr, logic [1:0] size, logic uns,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] exp_data, logic exp_mis, int exp_stall);
    mvec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_mis = exp_mis; v.exp_stall = exp_stall;
    return v;
  endfunction

  function automatic bvec_t mkb(logic br, logic bne, logic zero, logic jmp, logic jr,
                                logic exp_src, logic [31:0] exp_tgt);
    bvec_t v;
    v.br = br; v.bne = bne; v.zero = zero; v.jmp = jmp; v.jr = jr;
    v.exp_src = exp_src; v.exp_tgt = exp_tgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_mem();
    M_MemRead = 0; M_MemWrite = 0; M_MemSize = 2'b00; M_LoadUnsigned = 0;
    M_ALUResult = 0; M_WriteMemData = 0;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    M_MemRead = rd; M_MemWrite = wr; M_MemSize = size; M_LoadUnsigned = uns;
    M_ALUResult = addr; M_WriteMemData = wdata;
  endtask

  // Drive one access on the wait-state instance; pop and score it at completion.
  task automatic run_mvec(input mvec_t v, input int k);
    int stalls;
    bit done;
    logic [31:0] exp_d;
    stalls = 0;
    done = 0;
    drive_mem(v.rd, v.wr, v.size, v.uns, v.addr, v.wdata);
    exp_q.push_back(v.exp_data);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      if (stall2) begin
        stalls++;
        @(posedge Clk); #1;
      end else begin
        done = 1;
        exp_d = exp_q.pop_front();
        check($sformatf("mvec%0d data", k), rdata2, exp_d);
        check($sformatf("mvec%0d misalign", k), {31'b0, mis2}, {31'b0, v.exp_mis});
        check($sformatf("mvec%0d stalls", k), 32'(stalls), 32'(v.exp_stall));
        $display("mvec %0d addr=%h rd=%0d wr=%0d size=%0d data=%h stalls=%0d",
                 k, v.addr, v.rd, v.wr, v.size, rdata2, stalls);
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL mvec%0d timeout: got stall held expected completion", k);
      exp_q.delete();
    end
    @(posedge Clk); #1;
    idle_mem();
  endtask

  initial begin
    Reset = 0;
    idle_mem();
    M_Branch = 0; M_BNE = 0; M_ZeroFlag = 0; M_jump = 0; M_jr = 0;
    M_offset = 26'h10; M_PCinc = 32'h8000_0004; M_BranchAddResult = 32'h40;
    M_Read1 = 32'hCAFE_F00C;

    // Reset state: outputs held at 0 even with a request and a jump presented.
    drive_mem(1, 0, 2'b00, 0, 32'h10, 0);
    M_jump = 1;
    #12;
    check("rst stall", {31'b0, stall2}, 32'h0);
    check("rst data", rdata2, 32'h0);
    check("rst pcsrc", {31'b0, pcsrc2}, 32'h0);
    check("rst target", target2, 32'h0);
    M_jump = 0;
    idle_mem();
    #5 Reset = 1;
    @(posedge Clk); #1;

    mvecs.push_back(mk(0, 1, 2'b00, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2));
    mvecs.push_back(mk(1, 0, 2'b00, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b10, 0, 32'h13,   32'h0,        32'hFFFFFFDE, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b10, 1, 32'h13,   32'h0,        32'h000000DE, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b01, 0, 32'h12,   32'h0,        32'hFFFFDEAD, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b01, 1, 32'h10,   32'h0,        32'h0000BEEF, 0, 2));
    mvecs.push_back(mk(0, 1, 2'b10, 0, 32'h11,   32'h00000055, 32'h0,        0, 2));
    mvecs.push_back(mk(1, 0, 2'b00, 0, 32'h10,   32'h0,        32'hDEAD55EF, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b00, 0, 32'h11,   32'h0,        32'h0,        1, 0));
    mvecs.push_back(mk(0, 1, 2'b01, 0, 32'h13,   32'hFFFF,     32'h0,        1, 0));
    mvecs.push_back(mk(0, 1, 2'b01, 0, 32'h12,   32'h1234ABCD, 32'h0,        0, 2));
    mvecs.push_back(mk(1, 0, 2'b00, 0, 32'h10,   32'h0,        32'hABCD55EF, 0, 2));
    mvecs.push_back(mk(1, 1, 2'b00, 0, 32'h14,   32'h11223344, 32'h0,        0, 2));
    mvecs.push_back(mk(1, 0, 2'b11, 0, 32'h14,   32'h0,        32'h11223344, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b00, 0, 32'h1010, 32'h0,        32'hABCD55EF, 0, 2));
    mvecs.push_back(mk(1, 0, 2'b10, 0, 32'h10,   32'h0,        32'hFFFFFFEF, 0, 2));
    mvecs.push_back(mk(0, 1, 2'b00, 0, 32'h20,   32'hA5A5A5A5, 32'h0,        0, 2));
    foreach (mvecs[i]) run_mvec(mvecs[i], i);

    bvecs.push_back(mkb(1, 0, 1, 0, 0, 1, 32'h40));
    bvecs.push_back(mkb(1, 0, 0, 0, 0, 0, 32'h0));
    bvecs.push_back(mkb(0, 1, 1, 0, 0, 0, 32'h0));
    bvecs.push_back(mkb(0, 1, 0, 0, 0, 1, 32'h40));
    bvecs.push_back(mkb(0, 0, 0, 1, 0, 1, 32'h80000040));
    bvecs.push_back(mkb(0, 0, 0, 0, 1, 1, 32'hCAFEF00C));
    bvecs.push_back(mkb(0, 0, 0, 1, 1, 1, 32'hCAFEF00C));
    bvecs.push_back(mkb(1, 0, 1, 1, 0, 1, 32'h80000040));
    foreach (bvecs[i]) begin
      M_Branch = bvecs[i].br; M_BNE = bvecs[i].bne; M_ZeroFlag = bvecs[i].zero;
      M_jump = bvecs[i].jmp; M_jr = bvecs[i].jr;
      @(negedge Clk);
      check($sformatf("bvec%0d pcsrc", i), {31'b0, pcsrc2}, {31'b0, bvecs[i].exp_src});
      check($sformatf("bvec%0d target", i), target2, bvecs[i].exp_tgt);
      check($sformatf("bvec%0d flush", i), {31'b0, flush2}, {31'b0, bvecs[i].exp_src});
      $display("bvec %0d pcsrc=%0d target=%h", i, pcsrc2, target2);
      @(posedge Clk); #1;
    end
    M_Branch = 0; M_BNE = 0; M_ZeroFlag = 0; M_jump = 0; M_jr = 0;

    // Reset asserted while a store is waiting: stall drops at once, RAM untouched.
    drive_mem(0, 1, 2'b00, 0, 32'h20, 32'h1234);
    @(posedge Clk); #1;
    check("busy stall", {31'b0, stall2}, 32'h1);
    #2 Reset = 0;
    #1;
    check("rst mid-busy stall", {31'b0, stall2}, 32'h0);
    $display("reset mid-busy stall=%0d", stall2);
    @(posedge Clk); @(posedge Clk); #1;
    idle_mem();
    #2 Reset = 1;
    @(posedge Clk); #1;
    run_mvec(mk(1, 0, 2'b00, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, 2), 100);

    // Zero-wait instance: back-to-back stores then loads, one per cycle, never stalling.
    for (int i = 0; i < 8; i++) begin
      drive_mem(0, 1, 2'b00, 0, 32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h111));
      @(negedge Clk);
      check($sformatf("w0 sw%0d stall", i), {31'b0, stall0}, 32'h0);
      $display("w0 sw %0d stall=%0d", i, stall0);
      @(posedge Clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      drive_mem(1, 0, 2'b00, 0, 32'h100 + 32'(4 * i), 32'h0);
      exp_q.push_back(32'h1000_0000 + 32'(i * 32'h111));
      @(negedge Clk);
      check($sformatf("w0 lw%0d data", i), rdata0, exp_q.pop_front());
      check($sformatf("w0 lw%0d stall", i), {31'b0, stall0}, 32'h0);
      $display("w0 lw %0d data=%h stall=%0d", i, rdata0, stall0);
      @(posedge Clk); #1;
    end
    idle_mem();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
